// File: rtl/mefi_board_emu.sv
// -----------------------------------------------------------------------------
// mefi_board_emu
//
// Emulates the button/LED board behind a multiplexed 8x8 matrix scanner.
// The scanner drives one row at a time (BROW) together with that row's LED
// columns (BCOL_LED). The emulator answers with the pressed buttons of the
// selected row on BCOL_SENSE (active-low). It also assembles the LED columns
// of all eight rows into a frame, which is published on LEDS.
//
// A row is trusted only after it has been one-hot and unchanged for SETTLE
// synchronized cycles. Multi-hot row drive is flagged on ROW_ERR and never
// captured.
//
// Ports
//   CLK         sole clock, rising edge
//   RST_N       asynchronous active-low reset
//   BROW[7:0]   row select from scanner (bit k = row k, zero = blanking)
//   BCOL_LED    LED column drive for the selected row
//   PRESSED     emulated button state, bit 8*r+c = button (r,c)
//   BCOL_SENSE  registered, active-low column sense for the selected row
//   LEDS        last complete LED frame, bit 8*r+c = LED (r,c)
//   FRAME_STB   one-cycle pulse when LEDS updates
//   ROW_ERR     one-cycle pulse on entry into a multi-hot row condition
//   CUR_ROW     index of the most recently settled row
//   ROW_VALID   high while a settled row is being held
// -----------------------------------------------------------------------------
module mefi_board_emu #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  BROW,
  input  logic [7:0]  BCOL_LED,
  input  logic [63:0] PRESSED,
  output logic [7:0]  BCOL_SENSE,
  output logic [63:0] LEDS,
  output logic        FRAME_STB,
  output logic        ROW_ERR,
  output logic [2:0]  CUR_ROW,
  output logic        ROW_VALID
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  // Two-flop synchronizers; everything downstream uses s_row / s_col.
  logic [7:0] row_meta, s_row;
  logic [7:0] col_meta, s_col;

  logic [1:0]  state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  row_k, row_k_nxt;
  logic [63:0] shadow;
  logic [7:0]  mask, mask_nxt;

  logic       row_blank, row_multi, row_onehot;
  logic [2:0] row_idx;
  logic       start;
  logic       capture;
  logic       commit;

  // Row classification: clearing the lowest set bit leaves something behind
  // only if two or more bits were set.
  assign row_blank  = (s_row == 8'h00);
  assign row_multi  = ((s_row & (s_row - 8'h01)) != 8'h00);
  assign row_onehot = !row_blank && !row_multi;

  always_comb begin
    row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (s_row[i]) row_idx = 3'(i);
    end
  end

  // A full mask means the shadow holds a complete frame; it is copied out on
  // the following cycle.
  assign commit = (mask == 8'hFF);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_k_nxt = row_k;
    start     = 1'b0;
    capture   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (row_multi)       state_nxt = ST_ERR;
        else if (row_onehot) start     = 1'b1;
      end
      ST_SETTLE: begin
        if (row_multi)                 state_nxt = ST_ERR;
        else if (row_blank)            state_nxt = ST_IDLE;
        else if (row_idx != row_k)     start     = 1'b1;
        else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt + 8'd1 == SETTLE_CNT) begin
            state_nxt = ST_HOLD;
            capture   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (row_multi)             state_nxt = ST_ERR;
        else if (row_blank)        state_nxt = ST_IDLE;
        else if (row_idx != row_k) start     = 1'b1;
      end
      default: begin  // ST_ERR
        if (row_blank)       state_nxt = ST_IDLE;
        else if (row_onehot) start     = 1'b1;
      end
    endcase

    // Any (re)start of settling counts its first cycle. With SETTLE = 1 that
    // first cycle already satisfies the requirement, so go straight to HOLD.
    if (start) begin
      row_k_nxt = row_idx;
      cnt_nxt   = 8'd1;
      if (SETTLE_CNT == 8'd1) begin
        state_nxt = ST_HOLD;
        capture   = 1'b1;
      end else begin
        state_nxt = ST_SETTLE;
      end
    end
  end

  // A capture on the commit cycle starts the next frame with only its own bit.
  always_comb begin
    mask_nxt = commit ? 8'h00 : mask;
    if (capture) mask_nxt[row_k_nxt] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values. This is what lets the commit copy
  // the old shadow while a coincident capture writes the new row.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_meta   <= 8'h00;
      s_row      <= 8'h00;
      col_meta   <= 8'h00;
      s_col      <= 8'h00;
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      row_k      <= 3'd0;
      // NOTE: the shadow frame is reset on purpose. A reset mid-frame must not
      // let stale rows leak into the next published frame.
      shadow     <= 64'd0;
      mask       <= 8'h00;
      LEDS       <= 64'd0;
      FRAME_STB  <= 1'b0;
      ROW_ERR    <= 1'b0;
      CUR_ROW    <= 3'd0;
      ROW_VALID  <= 1'b0;
      BCOL_SENSE <= 8'hFF;
    end else begin
      row_meta <= BROW;
      s_row    <= row_meta;
      col_meta <= BCOL_LED;
      s_col    <= col_meta;

      state <= state_nxt;
      cnt   <= cnt_nxt;
      row_k <= row_k_nxt;

      ROW_ERR   <= (state_nxt == ST_ERR) && (state != ST_ERR);
      ROW_VALID <= (state_nxt == ST_HOLD);
      if (capture) begin
        CUR_ROW                          <= row_k_nxt;
        shadow[{row_k_nxt, 3'b000} +: 8] <= s_col;
      end

      mask      <= mask_nxt;
      FRAME_STB <= commit;
      if (commit) LEDS <= shadow;

      BCOL_SENSE <= row_onehot ? ~PRESSED[{row_idx, 3'b000} +: 8] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_mefi_board_emu.sv
// -----------------------------------------------------------------------------
// tb_mefi_board_emu
//
// Bench for mefi_board_emu. dut4 uses SETTLE = 4. dut1 uses SETTLE = 1 and
// covers the commit/capture collision. Both instances share the same stimulus.
// dut4 frame strobes are scored against a queue of expected frames. Sense
// latency is scored against a queue of expected values tagged with due cycles.
// -----------------------------------------------------------------------------
module tb_mefi_board_emu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  BROW;
  logic [7:0]  BCOL_LED;
  logic [63:0] PRESSED;

  logic [7:0]  sense4, sense1;
  logic [63:0] leds4, leds1;
  logic        stb4, stb1, err4, err1, valid4, valid1;
  logic [2:0]  cur4, cur1;

  always #5 CLK = ~CLK;

  mefi_board_emu #(.SETTLE(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .BROW(BROW), .BCOL_LED(BCOL_LED),
    .PRESSED(PRESSED), .BCOL_SENSE(sense4), .LEDS(leds4), .FRAME_STB(stb4),
    .ROW_ERR(err4), .CUR_ROW(cur4), .ROW_VALID(valid4)
  );

  mefi_board_emu #(.SETTLE(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .BROW(BROW), .BCOL_LED(BCOL_LED),
    .PRESSED(PRESSED), .BCOL_SENSE(sense1), .LEDS(leds1), .FRAME_STB(stb1),
    .ROW_ERR(err1), .CUR_ROW(cur1), .ROW_VALID(valid1)
  );

  typedef struct {
    logic [7:0] brow;
    logic [7:0] exp_sense;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] exp;
  } sb_t;

  vec_t        vecs[8];
  sb_t         sense_q[$];
  logic [63:0] frame_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int stb1_cnt = 0;
  int err4_cnt = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock. Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [63:0] e;
    @(posedge CLK);
    #1;
    cyc++;
    if (stb4) begin
      if (frame_q.size() == 0) begin
        check("frame_unexpected", {63'd0, stb4}, 64'd0);
      end else begin
        e = frame_q.pop_front();
        check("frame_leds", leds4, e);
      end
    end
    if (stb1) stb1_cnt++;
    if (err4) err4_cnt++;
  endtask

  task automatic drain_sense();
    sb_t s;
    while (sense_q.size() > 0 && sense_q[0].due == cyc) begin
      s = sense_q.pop_front();
      check("sense_vec", {56'd0, sense4}, {56'd0, s.exp});
      check("sense_vec_s1", {56'd0, sense1}, {56'd0, s.exp});
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST_N    = 1'b0;
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic scan_row(input int r, input logic [7:0] col, input int hold);
    BROW     = 8'h01 << r;
    BCOL_LED = col;
    repeat (hold) tick();
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;

    RST_N    = 1'b1;
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    PRESSED  = 64'd0;

    // Reset values, observed before any clock edge.
    #1 RST_N = 1'b0;
    #2;
    check("rst_sense", {56'd0, sense4}, 64'h0000_0000_0000_00FF);
    check("rst_leds", leds4, 64'd0);
    check("rst_stb", {63'd0, stb4}, 64'd0);
    check("rst_err", {63'd0, err4}, 64'd0);
    check("rst_cur", {61'd0, cur4}, 64'd0);
    check("rst_valid", {63'd0, valid4}, 64'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    // Sense path: one vector per cycle, each due 3 cycles after it is driven.
    PRESSED = 64'h8000_0000_0020_0001;
    vecs[0] = '{8'h04, 8'hDF};
    vecs[1] = '{8'h00, 8'hFF};
    vecs[2] = '{8'h01, 8'hFE};
    vecs[3] = '{8'h80, 8'h7F};
    vecs[4] = '{8'h21, 8'hFF};
    vecs[5] = '{8'h02, 8'hFF};
    vecs[6] = '{8'h40, 8'hFF};
    vecs[7] = '{8'hC0, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      BROW = vecs[i].brow;
      sense_q.push_back('{cyc + 3, vecs[i].exp_sense});
      tick();
      drain_sense();
    end
    BROW = 8'h00;
    repeat (4) begin
      tick();
      drain_sense();
    end
    check("sense_q_empty", 64'(sense_q.size()), 64'd0);

    // Exact 3-cycle latency on a held row and on its release.
    do_reset();
    BROW = 8'h04;
    tick();
    tick();
    check("lat_on_2", {56'd0, sense4}, 64'h0000_0000_0000_00FF);
    tick();
    check("lat_on_3", {56'd0, sense4}, 64'h0000_0000_0000_00DF);
    BROW = 8'h00;
    tick();
    tick();
    check("lat_off_2", {56'd0, sense4}, 64'h0000_0000_0000_00DF);
    tick();
    check("lat_off_3", {56'd0, sense4}, 64'h0000_0000_0000_00FF);

    // Multi-hot drive: a single error pulse, then recovery onto row 0.
    do_reset();
    err4_cnt = 0;
    BROW = 8'h21;
    repeat (5) tick();
    check("multi_sense", {56'd0, sense4}, 64'h0000_0000_0000_00FF);
    check("multi_valid", {63'd0, valid4}, 64'd0);
    BROW = 8'h01;
    repeat (5) tick();
    check("recover_valid_early", {63'd0, valid4}, 64'd0);
    tick();
    check("recover_valid", {63'd0, valid4}, 64'd1);
    check("err_pulses", 64'(err4_cnt), 64'd1);

    // Short row: 3 cycles is one short of SETTLE, so no capture. The frame may
    // only commit once row 4 is captured by a proper scan.
    do_reset();
    seen = 1'b0;
    BROW = 8'h10;
    repeat (3) begin
      tick();
      if (valid4) seen = 1'b1;
    end
    BROW = 8'h00;
    repeat (6) begin
      tick();
      if (valid4) seen = 1'b1;
    end
    check("short_no_hold", {63'd0, seen}, 64'd0);
    for (int r = 0; r < 8; r++) begin
      if (r != 4) scan_row(r, 8'h00, 16);
    end
    frame_q.push_back(64'd0);
    scan_row(4, 8'h00, 16);
    check("short_frame_done", 64'(frame_q.size()), 64'd0);

    // Full scan, LED pattern on row 3 only.
    do_reset();
    for (int r = 0; r < 7; r++) scan_row(r, (r == 3) ? 8'h81 : 8'h00, 16);
    check("scan_cur_row", {61'd0, cur4}, 64'd6);
    frame_q.push_back(64'h0000_0000_8100_0000);
    scan_row(7, 8'h00, 16);
    check("scan_frame_done", 64'(frame_q.size()), 64'd0);
    check("scan_leds", leds4, 64'h0000_0000_8100_0000);

    // Reset after 5 rows captured, while row 4 is still held.
    PRESSED = 64'h0000_0001_0000_0000;
    for (int r = 0; r < 4; r++) scan_row(r, 8'(8'hA0 + r), 16);
    BROW     = 8'h10;
    BCOL_LED = 8'hA4;
    repeat (10) tick();
    check("pre_rst_valid", {63'd0, valid4}, 64'd1);
    check("pre_rst_sense", {56'd0, sense4}, 64'h0000_0000_0000_00FE);
    check("pre_rst_cur", {61'd0, cur4}, 64'd4);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    check("mid_rst_leds", leds4, 64'd0);
    check("mid_rst_sense", {56'd0, sense4}, 64'h0000_0000_0000_00FF);
    check("mid_rst_valid", {63'd0, valid4}, 64'd0);
    check("mid_rst_cur", {61'd0, cur4}, 64'd0);
    check("mid_rst_stb", {63'd0, stb4}, 64'd0);
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    for (int r = 0; r < 7; r++) scan_row(r, 8'(r + 1), 16);
    frame_q.push_back(64'h0807_0605_0403_0201);
    scan_row(7, 8'h08, 16);
    check("post_rst_frame_done", 64'(frame_q.size()), 64'd0);

    // SETTLE = 1: row 0 is re-captured on the same cycle as the commit.
    do_reset();
    stb1_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      BROW     = 8'h01 << r;
      BCOL_LED = 8'(8'h10 + r);
      tick();
    end
    BROW     = 8'h01;
    BCOL_LED = 8'hEE;
    tick();
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    repeat (4) tick();
    check("s1_stb_count_1", 64'(stb1_cnt), 64'd1);
    check("s1_leds_1", leds1, 64'h1716_1514_1312_1110);
    // The mask now holds only row 0, so seven more rows complete the frame.
    for (int r = 1; r < 8; r++) begin
      BROW     = 8'h01 << r;
      BCOL_LED = 8'(8'h10 + r);
      tick();
    end
    BROW     = 8'h00;
    BCOL_LED = 8'h00;
    repeat (4) tick();
    check("s1_stb_count_2", 64'(stb1_cnt), 64'd2);
    check("s1_leds_2", leds1, 64'h1716_1514_1312_11EE);
    check("s1_cur_row", {61'd0, cur1}, 64'd7);

    check("frame_q_empty", 64'(frame_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
